// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer. It feeds operand bits LSB-first to an external 1-bit slice,
// chains the slice carry, and assembles the result word with carry and zero flags.
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             s_a,
    output logic             s_b,
    output logic             s_o1,
    output logic             s_o2,
    output logic             s_o3,
    output logic             s_cin,
    input  logic             s_c,
    input  logic             s_cout
);
    localparam int            IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [2:0]    OP_ADD   = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q, carry_out_q, zero_q;

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        s_a                = 1'b0;
        s_b                = 1'b0;
        {s_o1, s_o2, s_o3} = 3'b000;
        s_cin              = 1'b0;
        if (state_q == RUN) begin
            s_a                = a_q[idx_q];
            s_b                = b_q[idx_q];
            {s_o1, s_o2, s_o3} = op_q;
            s_cin              = carry_q;
        end
    end

    // The result word with the slice's current bit merged in. This lets zero include the MSB.
    always_comb begin
        result_d = result_q;
        if (state_q == RUN) begin
            result_d[idx_q] = s_c;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        idx_q    <= '0;
                        carry_q  <= 1'b0;
                        result_q <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= s_cout;
                    if (idx_q == LAST_IDX) begin
                        carry_out_q <= (op_q == OP_ADD) ? s_cout : 1'b0;
                        zero_q      <= (result_d == '0);
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl: a word-level reference model predicts each operation,
// and a monitor checks the slice interface, the done timing and the held results.
module tb_serial_alu_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         co;
        logic         z;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0]   op = '0;
    logic         ready, busy, done, carry_out, zero;
    logic [W-1:0] result;
    logic         s_a, s_b, s_o1, s_o2, s_o3, s_cin, s_c, s_cout;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   have_prev = 0;
    bit   b2b = 0;
    logic [W-1:0] last_res = '0;
    exp_t sb_q[$];

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
        .ready(ready), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .zero(zero),
        .s_a(s_a), .s_b(s_b), .s_o1(s_o1), .s_o2(s_o2), .s_o3(s_o3),
        .s_cin(s_cin), .s_c(s_c), .s_cout(s_cout)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit slice. Carry-out is only meaningful for the add opcode.
    always_comb begin
        s_cout = 1'b0;
        case ({s_o1, s_o2, s_o3})
            3'b000:  s_c = s_a;
            3'b001:  s_c = s_b;
            3'b010:  s_c = ~s_a;
            3'b011:  s_c = ~s_b;
            3'b100:  s_c = s_a & s_b;
            3'b101:  s_c = s_a | s_b;
            3'b110:  s_c = s_a ^ s_b;
            default: begin
                s_c    = s_a ^ s_b ^ s_cin;
                s_cout = (s_a & s_b) | ((s_a ^ s_b) & s_cin);
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic [2:0] opv, input int acc);
        exp_t e;
        int   sum;
        sum = int'(av) + int'(bv);
        e.a = av; e.b = bv; e.op = opv; e.acc = acc;
        case (opv)
            3'b000:  e.res = av;
            3'b001:  e.res = bv;
            3'b010:  e.res = ~av;
            3'b011:  e.res = ~bv;
            3'b100:  e.res = av & bv;
            3'b101:  e.res = av | bv;
            3'b110:  e.res = av ^ bv;
            default: e.res = W'(sum);
        endcase
        e.co = (opv == 3'b111) ? ((sum >> W) & 1) != 0 : 1'b0;
        e.z  = (e.res == '0);
        return e;
    endfunction

    // Acceptance tracker: every accepted start pushes its predicted outcome.
    always @(posedge clk) begin
        if (!rst && start === 1'b1 && ready === 1'b1) begin
            sb_q.push_back(model(a, b, op, cyc));
            if (b2b && have_prev) check("b2b_spacing", cyc - last_acc, 10);
            last_acc  = cyc;
            have_prev = 1'b1;
        end
        cyc = cyc + 1;
    end

    // Monitor: checks the slice bits during RUN, idle outputs, done results and held results.
    always @(negedge clk) begin
        if (!rst) begin
            check("state_onehot", 32'(ready) + 32'(busy) + 32'(done), 1);
            if (busy && sb_q.size() > 0) begin
                int i, cin_exp, msk;
                i = cyc - sb_q[0].acc - 1;
                check("run_window", (i >= 0 && i < W), 1);
                if (i >= 0 && i < W) begin
                    check("s_a", s_a, sb_q[0].a[i]);
                    check("s_b", s_b, sb_q[0].b[i]);
                    check("s_op", {s_o1, s_o2, s_o3}, sb_q[0].op);
                    if (sb_q[0].op == 3'b111) begin
                        msk     = (1 << i) - 1;
                        cin_exp = (((int'(sb_q[0].a) & msk) + (int'(sb_q[0].b) & msk)) >> i) & 1;
                        check("s_cin", s_cin, cin_exp);
                    end
                end
            end else if (!busy) begin
                check("s_idle_zero", {s_a, s_b, s_o1, s_o2, s_o3, s_cin}, 0);
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", result, e.res);
                    check("carry_out", carry_out, e.co);
                    check("zero", zero, e.z);
                    check("latency", cyc - e.acc, W + 1);
                    last_res = e.res;
                end
            end
            if (ready) check("result_hold", result, last_res);
        end
    end

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] opv);
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 0, 1);
        a = av; b = bv; op = opv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {ready, busy, done}, 3'b100);
        check("rst_result", {result, carry_out, zero}, 0);
        check("rst_slice", {s_a, s_b, s_o1, s_o2, s_o3, s_cin}, 0);
        rst = 1'b0;

        // Directed cases: add with carry, logic ops and pass/unary ops.
        do_op(8'hFF, 8'h01, 3'b111);
        do_op(8'h3C, 8'h15, 3'b111);
        do_op(8'hA5, 8'h3C, 3'b110);
        do_op(8'hA5, 8'h3C, 3'b100);
        do_op(8'hA5, 8'h3C, 3'b101);
        do_op(8'h0F, 8'h80, 3'b010);
        do_op(8'h0F, 8'h80, 3'b011);
        do_op(8'h0F, 8'h80, 3'b000);
        do_op(8'h0F, 8'h80, 3'b001);

        // A start pulse while busy must be ignored.
        do_op(8'h01, 8'h01, 3'b111);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;

        // Reset in the middle of RUN aborts with no done pulse.
        do_op(8'h55, 8'h0F, 3'b111);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        last_res = '0;
        @(negedge clk);
        check("abort_ready", ready, 1);
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        do_op(8'h10, 8'h20, 3'b111);

        // Random operations.
        for (int k = 0; k < 30; k++) do_op(W'($urandom), W'($urandom), 3'($urandom));

        // Back-to-back: start held high continuously, with operands randomized every cycle.
        @(negedge clk);
        while (ready !== 1'b1) @(negedge clk);
        b2b = 1'b1; have_prev = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 50; k++) begin
            a = W'($urandom); b = W'($urandom); op = 3'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        b2b = 1'b0;

        begin
            int n = 0;
            while ((sb_q.size() != 0 || ready !== 1'b1) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("drain", sb_q.size(), 0);
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial sequencer that computes a WIDTH-bit ALU operation using a single external 1-bit ALU slice. It accepts a start request, latches both operands and the opcode, and presents one bit pair per cycle from LSB to MSB. It chains the slice carry between bits and assembles the result word, carry and zero flags. It sits between the register/operand logic and the 1-bit slice, which is instantiated alongside it by the parent.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- a  in  WIDTH  operand A, sampled on accepted start
- b  in  WIDTH  operand B, sampled on accepted start
- op  in  3  opcode {o1,o2,o3}, sampled on accepted start
- ready  out  1  high in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE
- result  out  WIDTH  assembled result; held until the next accepted start
- carry_out  out  1  final carry for op=111, else 0
- zero  out  1  result==0, valid with done, held like result
- s_a, s_b  out  1 each  bit pair driven to the slice
- s_o1, s_o2, s_o3  out  1 each  opcode driven to the slice
- s_cin  out  1  carry-in driven to the slice
- s_c, s_cout  in  1 each  slice result bit and carry-out

## Operation

Opcode meaning, with slice semantics per bit:
- 000 = A
- 001 = B
- 010 = ~A
- 011 = ~B
- 100 = A&B
- 101 = A|B
- 110 = A^B
- 111 = A+B+cin, with s_cout = (a&b)|((a^b)&cin)

FSM states and transitions:
- IDLE → RUN on start. Latch a, b, op; clear idx=0, carry=0 and the result register.
- RUN → RUN while idx<WIDTH-1; RUN → DONE when idx==WIDTH-1 at the clock edge.
- DONE → IDLE unconditionally after one cycle.

Per RUN cycle:
- Combinational: s_a=A_lat[idx], s_b=B_lat[idx], {s_o1,s_o2,s_o3}=op_lat, s_cin=carry.
- At the clock edge: result[idx]<=s_c, carry<=s_cout, idx<=idx+1.

Outputs outside RUN:
- In IDLE and DONE, all s_* outputs are 0.
- On entry to DONE: carry_out<=(op_lat==111)?carry:0 and zero<=(result==0), using the final assembled result including the MSB.

Arithmetic is modulo 2^WIDTH; overflow is visible only via carry_out. idx is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.

Boundary conditions:
- start while busy or done is ignored. There is no queueing, and latched operands are unaffected.
- a, b and op may change freely after acceptance.
- rst at any time, including mid-RUN, forces IDLE and aborts the operation with no done pulse.

## Timing

Reset values:
- ready=1, busy=0, done=0
- result=0, carry_out=0, zero=0
- all s_*=0, idx=0, carry=0

Cycle sequence:
- Start is accepted at the edge ending cycle T (start=1, ready=1).
- Cycles T+1 … T+WIDTH: busy=1, bit i is presented in cycle T+1+i.
- Cycle T+WIDTH+1: done=1, with result, carry_out and zero valid.
- Cycle T+WIDTH+2: ready=1. The earliest next acceptance is at the end of this cycle.

Latency and throughput:
- Latency from accepted start to done is WIDTH+1 cycles.
- Throughput is one operation per WIDTH+2 cycles.
- ready, busy and done are mutually exclusive and decoded from state only.

## Test plan

All cases use WIDTH=8 and a behavioural model of the 1-bit slice.
- Add with carry: a=0xFF, b=0x01, op=111 → done 9 cycles after acceptance, result=0x00, carry_out=1, zero=1. Also a=0x3C, b=0x15 → 0x51, carry_out=0, zero=0.
- Logic ops: a=0xA5, b=0x3C with op=110 → 0x99; op=100 → 0x24; op=101 → 0xBD. carry_out=0 for all three.
- Unary/pass ops: a=0x0F, b=0x80 with op=010 → 0xF0; op=011 → 0x7F; op=000 → 0x0F; op=001 → 0x80. Check s_a/s_b follow a and b LSB-first each RUN cycle.
- Start while busy: accept a=0x01, b=0x01, op=111. Pulse start with a=0xFF in cycle T+3 → ignored; result=0x02, exactly one done pulse.
- Reset mid-RUN: rst in cycle T+4 → next cycle ready=1, result=0, no done pulse. A subsequent start with 0x10+0x20 → 0x30.
- Back-to-back: assert start continuously → operations accepted every 10 cycles. Results held between done pulses, and result changes only after an acceptance.
